uart_fifo_tx: RTL and testbench

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

---
 rtl/uart_fifo_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_fifo_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_tx
// Function : Pops bytes from a registered-output FIFO and sends them LSB first
//            as 8N1 frames, or 8E1 when UART_FIFO_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] buf_out,
  input  logic       buf_empty,
  output logic       rd_en,
  output logic       tx,
  output logic       busy
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_FIFO_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd6
  } state_t;
`endif

  state_t           state_q;
  logic [7:0]       shift_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_q;
  logic             rd_en_q;
  logic             busy_q;
`ifdef UART_FIFO_TX_PARITY_EN
  logic             parity_q;
`endif

  logic bit_done;
  assign bit_done = (cnt_q == LAST_CNT);

  // Every output is set on the edge that enters the state it belongs to,
  // so rd_en is high exactly in FETCH and tx never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_FIFO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!buf_empty) begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        FETCH: begin
          state_q <= LOAD;
        end

        // buf_out was refreshed by the FIFO on the edge that ended FETCH.
        LOAD: begin
          shift_q  <= buf_out;
`ifdef UART_FIFO_TX_PARITY_EN
          parity_q <= ^buf_out;
`endif
          cnt_q    <= '0;
          tx_q     <= 1'b0;
          state_q  <= START;
        end

        START: begin
          if (bit_done) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
`ifdef UART_FIFO_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef UART_FIFO_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_en = rd_en_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_tx.sv
`default_nettype none
// Bench for uart_fifo_tx: a queue-based FIFO model feeds the DUT and the tx
// trace is decoded back into bytes and compared with what was queued.
module tb_uart_fifo_tx;

  localparam int CPB = 4;
`ifdef UART_FIFO_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] buf_out   = 8'h00;
  logic       buf_empty = 1'b1;
  logic       rd_en;
  logic       tx;
  logic       busy;

  uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .buf_out   (buf_out),
    .buf_empty (buf_empty),
    .rd_en     (rd_en),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_pops = 0;
  logic       rd_prev = 1'b0;
  logic       force_nonempty = 1'b0;
  logic [7:0] fifo[$];
  logic [7:0] sent[$];
  logic       tx_h[$];
  logic       rd_h[$];
  logic       busy_h[$];
  logic [7:0] dec_bytes[$];
  int         dec_gaps[$];
  int         dec_starts[$];
  logic       dec_par[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: FIFO model reacts to the pop seen at this edge, then record.
  task automatic step();
    @(posedge clk);
    #1;
    if (rd_prev) begin
      n_pops++;
      check_eq("pop_nonempty", (fifo.size() > 0), 1);
      if (fifo.size() > 0) buf_out = fifo.pop_front();
    end
    buf_empty = (fifo.size() == 0) && !force_nonempty;
    rd_prev   = rd_en;
    tx_h.push_back(tx);
    rd_h.push_back(rd_en);
    busy_h.push_back(busy);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    sent.push_back(b);
    buf_empty = 1'b0;
  endtask

  task automatic clear_trace();
    tx_h.delete();
    rd_h.delete();
    busy_h.delete();
    sent.delete();
    n_pops = 0;
  endtask

  task automatic decode_trace();
    int         i;
    int         last_end;
    logic       ok;
    logic [7:0] b;
    dec_bytes.delete();
    dec_gaps.delete();
    dec_starts.delete();
    dec_par.delete();
    i = 0;
    last_end = -1;
    while (i < tx_h.size()) begin
      if (tx_h[i] == 1'b0) begin
        if (i + FRAME > tx_h.size()) begin
          check_eq("frame_complete", tx_h.size(), i + FRAME);
          break;
        end
        ok = 1'b1;
        for (int k = 0; k < NBITS; k++)
          for (int j = 1; j < CPB; j++)
            if (tx_h[i + k*CPB + j] !== tx_h[i + k*CPB]) ok = 1'b0;
        check_eq("bit_hold", ok, 1);
        for (int k = 0; k < 8; k++) b[k] = tx_h[i + (k+1)*CPB];
        check_eq("stop_bit", tx_h[i + (NBITS-1)*CPB], 1);
`ifdef UART_FIFO_TX_PARITY_EN
        dec_par.push_back(tx_h[i + 9*CPB]);
        check_eq("parity_bit", tx_h[i + 9*CPB], ^b);
`endif
        if (last_end >= 0) dec_gaps.push_back(i - last_end);
        dec_bytes.push_back(b);
        dec_starts.push_back(i);
        last_end = i + FRAME;
        i = last_end;
      end else begin
        i++;
      end
    end
  endtask

  function automatic int count_ones(input int from, input int sel);
    int n = 0;
    for (int i = from; i < tx_h.size(); i++) begin
      if (sel == 0 && rd_h[i])    n++;
      if (sel == 1 && busy_h[i])  n++;
      if (sel == 2 && !tx_h[i])   n++;
    end
    return n;
  endfunction

  initial begin
    int pushed;
    int cycles;
    int viol;

    // Reset held with a non-empty flag: no pop may happen.
    clear_trace();
    force_nonempty = 1'b1;
    buf_empty = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 4; i++) check_eq("rst_rd_en", rd_h[i], 0);
    check_eq("rst_tx", tx_h[3], 1);
    check_eq("rst_busy", busy_h[3], 0);
    force_nonempty = 1'b0;
    buf_empty = 1'b1;
    rst = 1'b0;
    repeat (3) step();

    // Single frame 0x55.
    clear_trace();
    push_byte(8'h55);
    repeat (FRAME + 20) step();
    decode_trace();
    check_eq("f55_count", dec_bytes.size(), 1);
    if (dec_bytes.size() > 0) begin
      check_eq("f55_byte", dec_bytes[0], 8'h55);
      check_eq("f55_start_idx", dec_starts[0], 2);
    end
    check_eq("f55_rd_first", rd_h[0], 1);
    check_eq("f55_rd_pulses", count_ones(0, 0), 1);
    check_eq("f55_busy_cycles", count_ones(0, 1), FRAME + 2);
    check_eq("f55_busy_end", busy_h[FRAME + 2], 0);
    check_eq("f55_pops", n_pops, 1);

    // Back-to-back frames 0x01, 0x02.
    clear_trace();
    push_byte(8'h01);
    push_byte(8'h02);
    repeat (2*FRAME + 30) step();
    decode_trace();
    check_eq("b2b_count", dec_bytes.size(), 2);
    if (dec_bytes.size() == 2) begin
      check_eq("b2b_byte0", dec_bytes[0], 8'h01);
      check_eq("b2b_byte1", dec_bytes[1], 8'h02);
      check_eq("b2b_gap", dec_gaps[0], 3);
    end
    check_eq("b2b_rd_pulses", count_ones(0, 0), 2);

    // Empty FIFO for 200 cycles.
    clear_trace();
    repeat (200) step();
    check_eq("idle_rd", count_ones(0, 0), 0);
    check_eq("idle_busy", count_ones(0, 1), 0);
    check_eq("idle_tx_low", count_ones(0, 2), 0);

    // Reset during data bit 3 of 0xA3 (bit 3 occupies trace 18..21).
    clear_trace();
    push_byte(8'hA3);
    repeat (19) step();
    check_eq("rstmid_bit3", tx_h[18], 0);
    check_eq("rstmid_busy_before", busy_h[18], 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstmid_tx", tx_h[19], 1);
    check_eq("rstmid_busy", busy_h[19], 0);
    check_eq("rstmid_rd", rd_h[19], 0);
    repeat (100) step();
    check_eq("rstmid_no_start", count_ones(20, 2), 0);
    check_eq("rstmid_no_busy", count_ones(20, 1), 0);
    check_eq("rstmid_pops", n_pops, 1);

`ifdef UART_FIFO_TX_PARITY_EN
    clear_trace();
    push_byte(8'h07);
    push_byte(8'h03);
    repeat (2*FRAME + 30) step();
    decode_trace();
    check_eq("par_count", dec_bytes.size(), 2);
    if (dec_bytes.size() == 2) begin
      check_eq("par_07", dec_par[0], 1);
      check_eq("par_03", dec_par[1], 0);
      check_eq("par_frame_span", dec_starts[1] - dec_starts[0], 44 + 3);
    end
`endif

    // Random stress: bytes arrive at random times, often mid-frame.
    clear_trace();
    pushed = 0;
    cycles = 0;
    while (pushed < 24 && cycles < 6000) begin
      if ($urandom_range(0, 29) == 0) begin
        push_byte(8'($urandom_range(0, 255)));
        pushed++;
      end
      step();
      cycles++;
    end
    cycles = 0;
    while ((fifo.size() > 0 || busy) && cycles < 3000) begin
      step();
      cycles++;
    end
    check_eq("stress_drained_busy", busy, 0);
    check_eq("stress_drained_fifo", fifo.size(), 0);
    repeat (5) step();
    decode_trace();
    check_eq("stress_count", dec_bytes.size(), sent.size());
    for (int i = 0; i < dec_bytes.size() && i < sent.size(); i++)
      check_eq("stress_byte", dec_bytes[i], sent[i]);
    check_eq("stress_pops", n_pops, sent.size());
    foreach (dec_gaps[i]) check_eq("stress_gap_min", (dec_gaps[i] >= 3), 1);
    viol = 0;
    for (int i = 1; i < rd_h.size(); i++) begin
      if (rd_h[i] && busy_h[i-1]) viol++;
      if (rd_h[i] && rd_h[i-1])   viol++;
    end
    check_eq("stress_rd_timing", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
